wordle_core: RTL
================

WORDLE_CORE -- requirements
Module: wordle_core

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- WORD_LEN, 4, letters per word (2..8).
- MAX_GUESSES, 6, guesses allowed before loss (1..15).
- SECRET, {5'd18,5'd19,5'd8,5'd1} ("BITS", slot 0 in LSBs), power-up secret.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- enter, in, 1, raw button level; a press is a 1->0 transition.
- back, in, 1, raw backspace level; a press is a 1->0 transition.
- letter, in, 5, letter code 0=A..25=Z; codes 26-31 are invalid.
- load_secret, in, 1, level; loads secret_in while idle.
- secret_in, in, 5*WORD_LEN, new secret; slot i at bits [5i+4:5i].
- guess_word, out, 5*WORD_LEN, current guess slots; blank slot = 5'h1F.
- pos, out, 4, number of letters entered (0..WORD_LEN).
- green, out, WORD_LEN, bit i set: slot i is the right letter in the right place.
- yellow, out, WORD_LEN, bit i set: slot i letter is present elsewhere in the secret.
- guess_cnt, out, 4, number of completed guesses.
- state, out, 3, IDLE=0, ENTRY=1, CHECK=2, SCAN=3, FEEDBACK=4, WIN=5, LOSE=6.
- fb_valid, out, 1, one-cycle pulse while in FEEDBACK.
- win, out, 1, high while in WIN.
- lose, out, 1, high while in LOSE.

Function
REQ-003 enter_q/back_q shall register the raw levels; press = q & ~level; a press acts in the same cycle it is detected; no further debounce.
REQ-004 IDLE: load_secret=1 with all secret_in slots <26 loads the secret; any invalid slot ignores the whole load.
REQ-004 (cont.) IDLE + enter press -> ENTRY; clears guess_word to all 5'h1F; pos=0; guess_cnt=0; green=0; yellow=0.
REQ-005 ENTRY + enter press with pos<WORD_LEN and letter<26: slot[pos] <= letter; pos++.
REQ-005 (cont.) Invalid letter, or pos==WORD_LEN with a non-enter action: no change.
REQ-006 ENTRY + back press with pos>0: pos--; slot[pos-1] <= 5'h1F. back press at pos=0 is ignored.
REQ-007 Simultaneous enter and back press: back wins; enter is discarded.
REQ-008 ENTRY + enter press with pos==WORD_LEN -> CHECK.
REQ-009 CHECK, one cycle: green[i] = (slot[i]==secret[i]) for all i in parallel; used mask <= green; yellow <= 0; scan index <= 0; -> SCAN.
REQ-010 SCAN, one slot i per cycle, i = 0..WORD_LEN-1:
- If !green[i], find the lowest j with !used[j] and secret[j]==slot[i].
- If found: yellow[i]=1 and used[j]=1.
- After slot WORD_LEN-1 -> FEEDBACK.
- Duplicate letters are thereby credited at most once per secret occurrence.
REQ-011 Latency: enter press in ENTRY to the first FEEDBACK cycle = WORD_LEN+2 cycles.
REQ-012 FEEDBACK, one cycle: fb_valid=1; guess_cnt++. Next state:
- green all ones -> WIN.
- otherwise, new guess_cnt==MAX_GUESSES -> LOSE.
- otherwise -> ENTRY, with pos=0 and slots blanked; green/yellow hold until the next CHECK.
REQ-013 WIN/LOSE: outputs hold; enter press -> IDLE. back and load_secret are ignored.
REQ-014 load_secret outside IDLE is ignored; the secret is never altered mid-game.
REQ-015 All outputs shall be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-016 rst=1 shall, immediately and regardless of clk or current state:
- set state=IDLE, secret=SECRET, guess_word all 5'h1F;
- set pos, green, yellow, guess_cnt, fb_valid, win, lose, enter_q, back_q, used and scan index to 0.
REQ-017 Release of rst shall produce no action until the first press detected after release; reset during CHECK/SCAN abandons the guess without incrementing guess_cnt.

Verification (WORD_LEN=4, MAX_GUESSES=6, secret BITS = 1,8,19,18)
REQ-018 Enter 1,8,19,18, press enter -> 6 cycles later fb_valid=1, green=4'b1111, yellow=0; next cycle win=1, guess_cnt=1.
REQ-019 Guess SSSS (18,18,18,18) -> green=4'b1000, yellow=4'b0000, return to ENTRY with pos=0.
REQ-020 Guess TSBI (19,18,1,8) -> green=0, yellow=4'b1111. Guess IIII -> green=4'b0010, yellow=0.
REQ-021 Six wrong guesses -> lose=1, guess_cnt=6; enter press -> IDLE; next enter press -> ENTRY with guess_cnt=0.
REQ-022 Entry edge cases:
- enter A(0), back -> pos=0, slot0=5'h1F.
- letter 27 + enter -> pos unchanged.
- simultaneous enter+back at pos=2 -> pos=1.
- enter at pos=4 -> CHECK.
REQ-023 Assert rst asynchronously during SCAN -> same cycle state=0, all outputs at reset values; load_secret with secret_in = AAAA in IDLE, then guess AAAA -> WIN.

Source files
------------

// File: rtl/wordle_if.sv
// Player/host bundle for wordle_core: button levels, letter entry, secret load
// and the registered game status returned by the core.
interface wordle_if #(
  parameter int WORD_LEN = 4
);
  logic                    enter;
  logic                    back;
  logic [4:0]              letter;
  logic                    load_secret;
  logic [5*WORD_LEN-1:0]   secret_in;
  logic [5*WORD_LEN-1:0]   guess_word;
  logic [3:0]              pos;
  logic [WORD_LEN-1:0]     green;
  logic [WORD_LEN-1:0]     yellow;
  logic [3:0]              guess_cnt;
  logic [2:0]              state;
  logic                    fb_valid;
  logic                    win;
  logic                    lose;

  modport master (
    output enter, back, letter, load_secret, secret_in,
    input  guess_word, pos, green, yellow, guess_cnt, state, fb_valid, win, lose
  );

  modport slave (
    input  enter, back, letter, load_secret, secret_in,
    output guess_word, pos, green, yellow, guess_cnt, state, fb_valid, win, lose
  );
endinterface

// File: rtl/wordle_core.sv
// Wordle game engine: letter entry with backspace, green/yellow scoring with
// duplicate-aware crediting (one slot per cycle), win/lose bookkeeping.
module wordle_core #(
  parameter int                    WORD_LEN    = 4,
  parameter int                    MAX_GUESSES = 6,
  parameter logic [5*WORD_LEN-1:0] SECRET      = {5'd18, 5'd19, 5'd8, 5'd1}
) (
  input  logic    clk,
  input  logic    rst,
  wordle_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTRY    = 3'd1,
    CHECK    = 3'd2,
    SCAN     = 3'd3,
    FEEDBACK = 3'd4,
    WIN      = 3'd5,
    LOSE     = 3'd6
  } state_t;

  localparam logic [3:0]          LEN_C   = 4'(WORD_LEN);
  localparam logic [3:0]          MAX_C   = 4'(MAX_GUESSES);
  localparam logic [4:0]          BLANK_C = 5'h1F;
  localparam logic [WORD_LEN-1:0] ONE_C   = {{(WORD_LEN-1){1'b0}}, 1'b1};

  state_t              state_r;
  logic [4:0]          slot_r   [WORD_LEN];
  logic [4:0]          secret_r [WORD_LEN];
  logic [3:0]          pos_r;
  logic [3:0]          idx_r;
  logic [3:0]          cnt_r;
  logic [WORD_LEN-1:0] green_r;
  logic [WORD_LEN-1:0] yellow_r;
  logic [WORD_LEN-1:0] used_r;
  logic                fb_valid_r;
  logic                win_r;
  logic                lose_r;
  logic                enter_q_r;
  logic                back_q_r;

  logic                enter_press_s;
  logic                back_press_s;
  logic                load_ok_s;
  logic                cur_green_s;
  logic                found_s;
  logic [4:0]          cur_slot_s;
  logic [WORD_LEN-1:0] green_cmp_s;
  logic [WORD_LEN-1:0] match_s;
  logic [WORD_LEN-1:0] hit_s;

  // Press detection, secret validity, exact-match vector and the scan search.
  always_comb begin
    enter_press_s = enter_q_r & ~bus.enter;
    back_press_s  = back_q_r & ~bus.back;
    load_ok_s     = 1'b1;
    cur_slot_s    = 5'd0;
    cur_green_s   = 1'b0;
    green_cmp_s   = '0;
    match_s       = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      load_ok_s      = load_ok_s & (bus.secret_in[5*i +: 5] < 5'd26);
      green_cmp_s[i] = (slot_r[i] == secret_r[i]);
      cur_slot_s     = cur_slot_s | ((idx_r == 4'(i)) ? slot_r[i] : 5'd0);
      cur_green_s    = cur_green_s | ((idx_r == 4'(i)) & green_r[i]);
    end
    for (int j = 0; j < WORD_LEN; j++) begin
      match_s[j] = ~used_r[j] & (secret_r[j] == cur_slot_s);
    end
    found_s = |match_s;
    // Isolate the lowest unused matching secret position.
    hit_s   = match_s & ((~match_s) + ONE_C);
  end

  // Flatten the slot registers onto the guess_word bus.
  always_comb begin
    bus.guess_word = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      bus.guess_word[5*i +: 5] = slot_r[i];
    end
  end

  assign bus.pos       = pos_r;
  assign bus.green     = green_r;
  assign bus.yellow    = yellow_r;
  assign bus.guess_cnt = cnt_r;
  assign bus.state     = state_r;
  assign bus.fb_valid  = fb_valid_r;
  assign bus.win       = win_r;
  assign bus.lose      = lose_r;

  // Game state machine with all status outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      pos_r      <= 4'd0;
      idx_r      <= 4'd0;
      cnt_r      <= 4'd0;
      green_r    <= '0;
      yellow_r   <= '0;
      used_r     <= '0;
      fb_valid_r <= 1'b0;
      win_r      <= 1'b0;
      lose_r     <= 1'b0;
      enter_q_r  <= 1'b0;
      back_q_r   <= 1'b0;
      for (int i = 0; i < WORD_LEN; i++) begin
        slot_r[i]   <= BLANK_C;
        secret_r[i] <= SECRET[5*i +: 5];
      end
    end else begin
      enter_q_r  <= bus.enter;
      back_q_r   <= bus.back;
      fb_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.load_secret && load_ok_s) begin
            for (int i = 0; i < WORD_LEN; i++) begin
              secret_r[i] <= bus.secret_in[5*i +: 5];
            end
          end
          if (enter_press_s) begin
            state_r  <= ENTRY;
            pos_r    <= 4'd0;
            cnt_r    <= 4'd0;
            green_r  <= '0;
            yellow_r <= '0;
            for (int i = 0; i < WORD_LEN; i++) begin
              slot_r[i] <= BLANK_C;
            end
          end
        end
        ENTRY: begin
          // Backspace takes priority; a simultaneous enter is dropped.
          if (back_press_s) begin
            if (pos_r != 4'd0) begin
              pos_r <= pos_r - 4'd1;
              for (int i = 0; i < WORD_LEN; i++) begin
                if (pos_r - 4'd1 == 4'(i)) slot_r[i] <= BLANK_C;
              end
            end
          end else if (enter_press_s) begin
            if (pos_r == LEN_C) begin
              state_r <= CHECK;
            end else if (bus.letter < 5'd26) begin
              for (int i = 0; i < WORD_LEN; i++) begin
                if (pos_r == 4'(i)) slot_r[i] <= bus.letter;
              end
              pos_r <= pos_r + 4'd1;
            end
          end
        end
        CHECK: begin
          green_r  <= green_cmp_s;
          used_r   <= green_cmp_s;
          yellow_r <= '0;
          idx_r    <= 4'd0;
          state_r  <= SCAN;
        end
        SCAN: begin
          for (int i = 0; i < WORD_LEN; i++) begin
            if (idx_r == 4'(i)) yellow_r[i] <= found_s & ~cur_green_s;
          end
          if (!cur_green_s) used_r <= used_r | hit_s;
          if (idx_r == LEN_C - 4'd1) begin
            state_r    <= FEEDBACK;
            fb_valid_r <= 1'b1;
          end else begin
            idx_r <= idx_r + 4'd1;
          end
        end
        FEEDBACK: begin
          cnt_r <= cnt_r + 4'd1;
          if (&green_r) begin
            state_r <= WIN;
            win_r   <= 1'b1;
          end else if (cnt_r + 4'd1 == MAX_C) begin
            state_r <= LOSE;
            lose_r  <= 1'b1;
          end else begin
            state_r <= ENTRY;
            pos_r   <= 4'd0;
            for (int i = 0; i < WORD_LEN; i++) begin
              slot_r[i] <= BLANK_C;
            end
          end
        end
        WIN, LOSE: begin
          if (enter_press_s) begin
            state_r <= IDLE;
            win_r   <= 1'b0;
            lose_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule
